io_register_bank: RTL and testbench
===================================

# io_register_bank

Parametrised memory-mapped I/O register bank that sits beside the block RAM in the memory manager and answers core port-1 accesses inside a configurable address window. It autonomously polls an I2C sensor front end, snapshots N sensor channels on each completed transfer, and exposes them together with status, control and writable actuator registers (servo angle and similar). Reads return one cycle after the request, matching block-RAM latency, so the core sees a uniform memory.

## Interface
- `BASE_ADDR`, 24'h002400, first address of the I/O window
- `NUM_SENSORS`, 8, sensor channels captured per transfer (1..32)
- `NUM_OUT_REGS`, 2, writable actuator registers (1..16)
- `DATA_WIDTH`, 16, register and bus data width
- `POLL_PERIOD`, 1_000_000, cycles between automatic poll requests (≥ 4)
- `TIMEOUT_CYCLES`, 2_000_000, max cycles waiting for `sensor_valid` before abort
- `clock1`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `bus_req`  in  1  access strobe from core port 1
- `bus_we`  in  1  1 = write, 0 = read
- `bus_addr`  in  24  word address
- `bus_wdata`  in  DATA_WIDTH  write data
- `io_hit`  out  1  registered; high the cycle after an in-window read
- `io_rdata`  out  DATA_WIDTH  registered read data, valid when `io_hit`
- `sensor_en`  out  1  request level to the I2C front end
- `sensor_valid`  in  1  front end done flag; rising edge = new packets
- `sensor_packets`  in  NUM_SENSORS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `out_regs`  out  NUM_OUT_REGS*DATA_WIDTH  actuator registers, reg 0 = servo angle

## Operation
- Address map (offset = `bus_addr - BASE_ADDR`): 0..NUM_SENSORS-1 sensor captures (RO); NUM_SENSORS status; NUM_SENSORS+1 control; NUM_SENSORS+2 .. NUM_SENSORS+1+NUM_OUT_REGS actuator regs (RW). Anything else is outside the window: no `io_hit`, no side effects.
- Status: bit0 fresh (W1C), bit1 busy (FSM not IDLE), bit2 timeout error (W1C), bits[15:8] capture count (wraps 255→0), others 0.
- Control (RW): bit0 auto-poll enable, bit1 one-shot request (self-clears next cycle), others read 0.
- Writes to sensor-capture offsets ignored. Reads have no side effects.
- Poll FSM: IDLE → REQUEST when (auto-poll and period counter reaches POLL_PERIOD-1) or one-shot written. REQUEST: `sensor_en`=1 one cycle → WAIT. WAIT: on `sensor_valid` rising edge (registered previous value) → CAPTURE; on timeout counter reaching TIMEOUT_CYCLES-1 → set error, → IDLE. CAPTURE: load all channels, set fresh, increment count → IDLE.
- Period counter free-runs while auto-poll enabled, cleared when disabled; a trigger arriving while busy is dropped.
- Simultaneous W1C of fresh and CAPTURE: capture wins, fresh stays 1. Same for timeout set vs clear.

## Timing
- Reset values: `io_hit`=0, `io_rdata`=0, `sensor_en`=0, all captures 0, `out_regs`=0, status=0, control=0, FSM IDLE, counters 0, previous-valid register 0.
- Read latency exactly 1 cycle: request in cycle T → `io_hit`/`io_rdata` in T+1, single-cycle pulse; back-to-back reads each produce one pulse.
- Write takes effect at end of request cycle; read of same register in T+1 returns new value.
- Captured data readable 1 cycle after CAPTURE; a read in the CAPTURE cycle returns old data.
- Reset mid-transfer: FSM to IDLE, `sensor_en` low next edge, captures cleared; a later `sensor_valid` edge with no request is ignored.

## Structure
- Package `io_map_pkg`: offset constants (status, control, first actuator), status bit indices, FSM state enum (IDLE, REQUEST, WAIT, CAPTURE).
- Sub-module `sensor_poll_fsm`: FSM, period and timeout counters, edge detect; outputs capture strobe, busy, timeout pulse. Top holds register file and bus decode.

## Test plan
- Reset, read BASE+8 → `io_hit` next cycle, `io_rdata`=0x0000; read BASE+12 → no `io_hit`.
- Write 0x005A to BASE+10 → `out_regs[15:0]`=0x005A next cycle; read BASE+10 returns 0x005A.
- Write 0x0002 to control, model raises `sensor_valid` 20 cycles later with channel k = 0x0100+k → BASE+3 reads 0x0103, status = 0x0101.
- Auto-poll with POLL_PERIOD=16: `sensor_en` pulses every 16 cycles while idle; disable → pulses stop.
- No `sensor_valid` within TIMEOUT_CYCLES → status bit2=1, busy=0, captures unchanged; write 0x0004 to status clears it.
- W1C fresh in same cycle as CAPTURE → fresh remains 1; reset asserted in WAIT → `sensor_en`=0, status=0 next cycle.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared address-map offsets, status/control bit positions and poll FSM states
// for the memory-mapped sensor/actuator register bank.
package io_map_pkg;

  // Register offsets measured from the end of the sensor-capture block
  localparam int unsigned STATUS_REL = 0;
  localparam int unsigned CONTROL_REL = 1;
  localparam int unsigned ACT_REL = 2;

  localparam int unsigned ST_FRESH_BIT = 0;
  localparam int unsigned ST_BUSY_BIT = 1;
  localparam int unsigned ST_ERR_BIT = 2;
  localparam int unsigned ST_CNT_LSB = 8;

  localparam int unsigned CTRL_AUTO_BIT = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_CAPTURE
  } poll_state_e;

  function automatic logic [15:0] pack_status(input logic fresh, input logic busy,
                                              input logic err, input logic [7:0] cnt);
    logic [15:0] res;
    res = '0;
    res[ST_FRESH_BIT] = fresh;
    res[ST_BUSY_BIT] = busy;
    res[ST_ERR_BIT] = err;
    res[ST_CNT_LSB +: 8] = cnt;
    return res;
  endfunction

endpackage

// File: rtl/sensor_poll_fsm.sv
// Sequences I2C front-end transfers: periodic or one-shot request, wait for the
// done edge with a timeout, then strobe a capture of all channels.
//
//   state     | meaning
//   S_IDLE    | no transfer in flight; waiting for period tick or one-shot
//   S_REQUEST | sensor_en high for exactly one cycle
//   S_WAIT    | waiting for sensor_valid rising edge, timeout counter running
//   S_CAPTURE | capture strobe high; register file loads all channels
module sensor_poll_fsm
  import io_map_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clock1,
  input  logic reset,
  input  logic auto_en,
  input  logic oneshot,
  input  logic sensor_valid,
  output logic sensor_en,
  output logic capture,
  output logic busy,
  output logic timeout
);

  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  poll_state_e state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic vprev_q, vprev_d;
  logic per_hit;
  logic valid_rise;

  assign per_hit = auto_en && (per_q == PER_LAST);
  assign valid_rise = sensor_valid & ~vprev_q;

  always_comb begin
    state_d = state_q;
    tmo_d = '0;
    vprev_d = sensor_valid;
    timeout = 1'b0;

    // Period counter free-runs regardless of FSM state; ticks while busy are dropped
    if (!auto_en || per_hit) per_d = '0;
    else per_d = per_q + PW'(1);

    case (state_q)
      S_IDLE:    if (per_hit || oneshot) state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        if (valid_rise) begin
          state_d = S_CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock1) begin
    if (reset) begin
      state_q <= S_IDLE;
      per_q <= '0;
      tmo_q <= '0;
      vprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q <= per_d;
      tmo_q <= tmo_d;
      vprev_q <= vprev_d;
    end
  end

  assign sensor_en = (state_q == S_REQUEST);
  assign capture = (state_q == S_CAPTURE);
  assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/io_register_bank.sv
// Memory-mapped I/O window beside block RAM: sensor snapshots, status, control
// and actuator registers with one-cycle registered read latency.
module io_register_bank
  import io_map_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h002400,
  parameter int unsigned NUM_SENSORS = 8,
  parameter int unsigned NUM_OUT_REGS = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned POLL_PERIOD = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                               clock1,
  input  logic                               reset,
  input  logic                               bus_req,
  input  logic                               bus_we,
  input  logic [23:0]                        bus_addr,
  input  logic [DATA_WIDTH-1:0]              bus_wdata,
  output logic                               io_hit,
  output logic [DATA_WIDTH-1:0]              io_rdata,
  output logic                               sensor_en,
  input  logic                               sensor_valid,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0]  sensor_packets,
  output logic [NUM_OUT_REGS*DATA_WIDTH-1:0] out_regs
);

  localparam logic [23:0] OFF_STATUS = 24'(NUM_SENSORS + STATUS_REL);
  localparam logic [23:0] OFF_CONTROL = 24'(NUM_SENSORS + CONTROL_REL);
  localparam logic [23:0] OFF_ACT0 = 24'(NUM_SENSORS + ACT_REL);
  localparam logic [23:0] OFF_END = 24'(NUM_SENSORS + ACT_REL + NUM_OUT_REGS);

  logic [23:0] offset;
  logic in_win, rd_hit, wr_hit;
  logic capture, busy, timeout;

  logic [DATA_WIDTH-1:0] cap_q [NUM_SENSORS];
  logic [DATA_WIDTH-1:0] cap_d [NUM_SENSORS];
  logic [DATA_WIDTH-1:0] out_q [NUM_OUT_REGS];
  logic [DATA_WIDTH-1:0] out_d [NUM_OUT_REGS];
  logic fresh_q, fresh_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic auto_q, auto_d, oneshot_q, oneshot_d;
  logic io_hit_q, io_hit_d;
  logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;
  logic [DATA_WIDTH-1:0] status_word, ctrl_word, rd_word;

  // Addresses below BASE_ADDR wrap to huge offsets and fall outside the window
  assign offset = bus_addr - BASE_ADDR;
  assign in_win = (offset < OFF_END);
  assign rd_hit = bus_req & ~bus_we & in_win;
  assign wr_hit = bus_req & bus_we & in_win;

  sensor_poll_fsm #(
    .POLL_PERIOD    (POLL_PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_poll (
    .clock1       (clock1),
    .reset        (reset),
    .auto_en      (auto_q),
    .oneshot      (oneshot_q),
    .sensor_valid (sensor_valid),
    .sensor_en    (sensor_en),
    .capture      (capture),
    .busy         (busy),
    .timeout      (timeout)
  );

  always_comb begin
    status_word = DATA_WIDTH'(pack_status(fresh_q, busy, err_q, cnt_q));
    ctrl_word = '0;
    ctrl_word[CTRL_AUTO_BIT] = auto_q;
    ctrl_word[CTRL_ONESHOT_BIT] = oneshot_q;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (offset == 24'(k)) rd_word = cap_q[k];
    end
    if (offset == OFF_STATUS) rd_word = status_word;
    if (offset == OFF_CONTROL) rd_word = ctrl_word;
    for (int j = 0; j < NUM_OUT_REGS; j++) begin
      if (offset == OFF_ACT0 + 24'(j)) rd_word = out_q[j];
    end
    io_hit_d = rd_hit;
    io_rdata_d = rd_hit ? rd_word : io_rdata_q;
  end

  always_comb begin
    fresh_d = fresh_q;
    err_d = err_q;
    cnt_d = cnt_q;
    auto_d = auto_q;
    oneshot_d = 1'b0;
    cap_d = cap_q;
    out_d = out_q;

    if (wr_hit && offset == OFF_STATUS) begin
      if (bus_wdata[ST_FRESH_BIT]) fresh_d = 1'b0;
      if (bus_wdata[ST_ERR_BIT]) err_d = 1'b0;
    end
    if (wr_hit && offset == OFF_CONTROL) begin
      auto_d = bus_wdata[CTRL_AUTO_BIT];
      oneshot_d = bus_wdata[CTRL_ONESHOT_BIT];
    end
    for (int j = 0; j < NUM_OUT_REGS; j++) begin
      if (wr_hit && offset == OFF_ACT0 + 24'(j)) out_d[j] = bus_wdata;
    end

    // Hardware events override a same-cycle software clear
    if (capture) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        cap_d[k] = sensor_packets[k*DATA_WIDTH +: DATA_WIDTH];
      end
      fresh_d = 1'b1;
      cnt_d = cnt_q + 8'd1;
    end
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clock1) begin
    if (reset) begin
      cap_q <= '{default: '0};
      out_q <= '{default: '0};
      fresh_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      auto_q <= 1'b0;
      oneshot_q <= 1'b0;
      io_hit_q <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      cap_q <= cap_d;
      out_q <= out_d;
      fresh_q <= fresh_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      auto_q <= auto_d;
      oneshot_q <= oneshot_d;
      io_hit_q <= io_hit_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_OUT_REGS; j++) begin
      out_regs[j*DATA_WIDTH +: DATA_WIDTH] = out_q[j];
    end
  end

  assign io_hit = io_hit_q;
  assign io_rdata = io_rdata_q;

endmodule

// File: tb/tb_io_register_bank.sv
// Scoreboard bench for io_register_bank: reads push expected data, a negedge
// monitor pops and compares whenever io_hit is presented.
module tb_io_register_bank;

  localparam logic [23:0] BASE = 24'h002400;
  localparam int NS = 8;
  localparam int NO = 2;
  localparam int DW = 16;
  localparam logic [23:0] A_STATUS = BASE + 24'd8;
  localparam logic [23:0] A_CTRL = BASE + 24'd9;
  localparam logic [23:0] A_ACT0 = BASE + 24'd10;
  localparam logic [23:0] A_ACT1 = BASE + 24'd11;

  logic clock1 = 1'b0;
  logic reset = 1'b1;
  logic bus_req = 1'b0;
  logic bus_we = 1'b0;
  logic [23:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic io_hit;
  logic [DW-1:0] io_rdata;
  logic sensor_en;
  logic sensor_valid = 1'b0;
  logic [NS*DW-1:0] sensor_packets = '0;
  logic [NO*DW-1:0] out_regs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  string name_q[$];
  int cyc = 0;
  int pulse_q[$];
  bit model_on = 1'b0;
  bit force_pulse = 1'b0;
  int model_delay = 20;

  io_register_bank #(
    .BASE_ADDR      (BASE),
    .NUM_SENSORS    (NS),
    .NUM_OUT_REGS   (NO),
    .DATA_WIDTH     (DW),
    .POLL_PERIOD    (16),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clock1         (clock1),
    .reset          (reset),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .io_hit         (io_hit),
    .io_rdata       (io_rdata),
    .sensor_en      (sensor_en),
    .sensor_valid   (sensor_valid),
    .sensor_packets (sensor_packets),
    .out_regs       (out_regs)
  );

  always #5 clock1 = ~clock1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every io_hit pulse must match the oldest outstanding expectation
  always @(negedge clock1) begin
    cyc++;
    if (sensor_en) pulse_q.push_back(cyc);
    if (io_hit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hit", 32'(io_hit), 32'd0);
      end else begin
        logic [DW-1:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 32'(io_rdata), 32'(e));
      end
    end
  end

  // I2C front-end model: answers a request with a valid pulse after model_delay cycles
  initial begin
    forever begin
      @(negedge clock1);
      if ((model_on && sensor_en) || force_pulse) begin
        repeat (model_delay) @(posedge clock1);
        #1 sensor_valid = 1'b1;
        repeat (2) @(posedge clock1);
        #1 sensor_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock1);
      #1;
    end
  endtask

  task automatic rd(input logic [23:0] a, input logic [DW-1:0] e, input string nm);
    bus_req = 1'b1;
    bus_we = 1'b0;
    bus_addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock1);
    #1 bus_req = 1'b0;
  endtask

  task automatic rd_miss(input logic [23:0] a, input string nm);
    bus_req = 1'b1;
    bus_we = 1'b0;
    bus_addr = a;
    @(posedge clock1);
    #1 bus_req = 1'b0;
    @(negedge clock1);
    check(nm, 32'(io_hit), 32'd0);
    @(posedge clock1);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [DW-1:0] d);
    bus_req = 1'b1;
    bus_we = 1'b1;
    bus_addr = a;
    bus_wdata = d;
    @(posedge clock1);
    #1;
    bus_req = 1'b0;
    bus_we = 1'b0;
  endtask

  task automatic set_packets(input logic [DW-1:0] base);
    for (int k = 0; k < NS; k++) sensor_packets[k*DW +: DW] = base + DW'(k);
  endtask

  // Returns in the CAPTURE cycle (posedge+1 phase) once the model raises valid
  task automatic wait_capture(input string nm);
    int t;
    t = 0;
    while (!sensor_valid && t < 200) begin
      @(negedge clock1);
      t++;
    end
    check(nm, 32'(t < 200), 32'd1);
    @(posedge clock1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    reset = 1'b0;
    @(negedge clock1);
    check("rst_io_hit", 32'(io_hit), 32'd0);
    check("rst_io_rdata", 32'(io_rdata), 32'd0);
    check("rst_sensor_en", 32'(sensor_en), 32'd0);
    check("rst_out_regs", out_regs, 32'd0);
    @(posedge clock1);
    #1;

    rd(A_STATUS, 16'h0000, "rst_status");
    rd_miss(BASE + 24'd12, "miss_above_window");
    rd_miss(BASE - 24'd1, "miss_below_window");

    wr(A_ACT0, 16'h005A);
    rd(A_ACT0, 16'h005A, "servo_readback");
    check("servo_out", 32'(out_regs[15:0]), 32'h005A);
    wr(A_ACT1, 16'hBEEF);
    rd(A_ACT1, 16'hBEEF, "act1_readback");
    rd(A_ACT0, 16'h005A, "act0_b2b");
    check("out_regs_both", out_regs, 32'hBEEF_005A);
    wr(BASE + 24'd3, 16'hFFFF);
    rd(BASE + 24'd3, 16'h0000, "ro_capture_write");

    set_packets(16'h0100);
    model_on = 1'b1;
    model_delay = 20;
    wr(A_CTRL, 16'h0002);
    step(3);
    rd(A_STATUS, 16'h0002, "status_busy");
    step(40);
    rd(BASE + 24'd3, 16'h0103, "cap_ch3");
    rd(A_STATUS, 16'h0101, "status_fresh_cnt1");
    rd(BASE + 24'd0, 16'h0100, "cap_ch0");
    rd(BASE + 24'd7, 16'h0107, "cap_ch7");

    wr(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0100, "fresh_w1c");

    model_on = 1'b0;
    set_packets(16'h0200);
    wr(A_CTRL, 16'h0002);
    step(60);
    rd(A_STATUS, 16'h0104, "status_timeout");
    rd(BASE + 24'd3, 16'h0103, "cap_after_timeout");
    wr(A_STATUS, 16'h0004);
    rd(A_STATUS, 16'h0100, "err_w1c");

    model_on = 1'b1;
    model_delay = 8;
    set_packets(16'h0300);
    wr(A_CTRL, 16'h0002);
    wait_capture("capture_seen_1");
    wr(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0201, "fresh_w1c_vs_capture");
    rd(BASE + 24'd5, 16'h0305, "cap2_ch5");

    set_packets(16'h0400);
    wr(A_CTRL, 16'h0002);
    wait_capture("capture_seen_2");
    rd(BASE + 24'd1, 16'h0301, "read_in_capture_old");
    rd(BASE + 24'd1, 16'h0401, "read_after_capture_new");
    rd(A_STATUS, 16'h0301, "status_cnt3");

    model_delay = 3;
    pulse_q.delete();
    wr(A_CTRL, 16'h0001);
    step(90);
    wr(A_CTRL, 16'h0000);
    check("autopoll_pulses", 32'(pulse_q.size() >= 4), 32'd1);
    for (int i = 1; i < pulse_q.size(); i++) begin
      check("autopoll_interval", 32'(pulse_q[i] - pulse_q[i-1]), 32'd16);
    end
    step(10);
    pulse_q.delete();
    step(50);
    check("autopoll_stopped", 32'(pulse_q.size()), 32'd0);

    model_on = 1'b0;
    wr(A_CTRL, 16'h0002);
    step(5);
    reset = 1'b1;
    @(posedge clock1);
    #1 reset = 1'b0;
    pulse_q.delete();
    @(negedge clock1);
    check("midreset_sensor_en", 32'(sensor_en), 32'd0);
    check("midreset_out_regs", out_regs, 32'd0);
    @(posedge clock1);
    #1;
    rd(A_STATUS, 16'h0000, "midreset_status");
    rd(BASE + 24'd1, 16'h0000, "midreset_cap_cleared");
    model_delay = 1;
    force_pulse = 1'b1;
    step(1);
    force_pulse = 1'b0;
    step(8);
    rd(A_STATUS, 16'h0000, "stray_valid_ignored");
    rd(BASE + 24'd1, 16'h0000, "stray_valid_no_capture");
    step(3);
    check("no_request_after_reset", 32'(pulse_q.size()), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
